// File: rtl/stack_alu_pkg.sv
// Shared opcode encodings and FSM state type for the handshake stack ALU.
package stack_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_DUP  = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/stack_alu_mul.sv
// Iterative signed shift-add multiplier: one multiplier bit per cycle, the
// first iteration happens on the start edge so done rises N cycles later.
module stack_alu_mul #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           done
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic           busy;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;

  logic [2*N-1:0] cur_acc;
  logic [2*N-1:0] cur_mc;
  logic [N-1:0]   cur_mp;
  logic [CW-1:0]  cur_cnt;
  logic [2*N-1:0] addend;
  logic [2*N-1:0] step_acc;

  // The sign bit of the multiplier carries weight -2^(N-1), so the last
  // partial product is subtracted instead of added.
  always_comb begin
    cur_acc = acc;
    cur_mc  = mcand;
    cur_mp  = mplier;
    cur_cnt = cnt;
    if (start) begin
      cur_acc = '0;
      cur_mc  = {{N{a[N-1]}}, a};
      cur_mp  = b;
      cur_cnt = '0;
    end
    addend = '0;
    if (cur_mp[0]) begin
      addend = (cur_cnt == LAST) ? -cur_mc : cur_mc;
    end
    step_acc = cur_acc + addend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        acc    <= step_acc;
        mcand  <= cur_mc << 1;
        mplier <= cur_mp >> 1;
        cnt    <= cur_cnt + 1'b1;
        busy   <= (cur_cnt != LAST);
        done   <= (cur_cnt == LAST);
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/stack_alu_hs.sv
// Handshaked stack ALU with iterative multiply. Define STACK_ALU_SATURATE_EN
// to clamp overflowing ADD/SUB/MUL results instead of wrapping them.
module stack_alu_hs
  import stack_alu_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               opcode,
  input  logic [N-1:0]             input_data,
  output logic [N-1:0]             output_data,
  output logic                     out_valid,
  output logic                     overflow,
  output logic                     success,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0]   DEPTH_MAX = AW1'(DEPTH);
  localparam logic [AW:0]   DEPTH_TWO = AW1'(2);
  localparam logic [AW-1:0] IDX_ONE   = AW'(1);
  localparam logic [AW-1:0] IDX_TWO   = AW'(2);

  state_t state, state_nx;

  logic [N-1:0]   mem [DEPTH];
  logic [AW-1:0]  push_idx, top_idx, sec_idx;
  logic [N-1:0]   t_val, s_val;
  logic           two_ok;

  logic [N:0]     add_full, sub_full, ar_full;
  logic           ar_ovf;
  logic [N-1:0]   ar_res;
  logic [2*N-1:0] mul_prod;
  logic           mul_ovf;
  logic [N-1:0]   mul_res;
  logic           mul_start, mul_done;

  logic           out_valid_nx, ovf_nx, succ_nx;
  logic [N-1:0]   data_nx;
  logic [AW:0]    depth_nx;
  logic           wr_en, wr2_en;
  logic [AW-1:0]  wr_idx, wr2_idx;
  logic [N-1:0]   wr_data, wr2_data;

  // Index arithmetic wraps mod DEPTH, so depth == DEPTH maps top to DEPTH-1.
  assign push_idx = depth[AW-1:0];
  assign top_idx  = push_idx - IDX_ONE;
  assign sec_idx  = push_idx - IDX_TWO;
  assign t_val    = mem[top_idx];
  assign s_val    = mem[sec_idx];
  assign two_ok   = (depth >= DEPTH_TWO);

  assign full     = (depth == DEPTH_MAX);
  assign empty    = (depth == '0);
  assign in_ready = (state == IDLE);

  assign add_full = {s_val[N-1], s_val} + {t_val[N-1], t_val};
  assign sub_full = {s_val[N-1], s_val} - {t_val[N-1], t_val};
  assign ar_full  = (opcode == OP_SUB) ? sub_full : add_full;
  assign ar_ovf   = ar_full[N] ^ ar_full[N-1];
  assign mul_ovf  = (mul_prod != {{N{mul_prod[N-1]}}, mul_prod[N-1:0]});

`ifdef STACK_ALU_SATURATE_EN
  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  assign ar_res  = ar_ovf  ? (ar_full[N]        ? SAT_MIN : SAT_MAX) : ar_full[N-1:0];
  assign mul_res = mul_ovf ? (mul_prod[2*N-1]   ? SAT_MIN : SAT_MAX) : mul_prod[N-1:0];
`else
  assign ar_res  = ar_full[N-1:0];
  assign mul_res = mul_prod[N-1:0];
`endif

  stack_alu_mul #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (s_val),
    .b       (t_val),
    .product (mul_prod),
    .done    (mul_done)
  );

  // Completion status is held between completions; an illegal command only
  // clears success and overflow and leaves the stack and output_data alone.
  always_comb begin
    state_nx     = state;
    out_valid_nx = 1'b0;
    data_nx      = output_data;
    ovf_nx       = overflow;
    succ_nx      = success;
    depth_nx     = depth;
    wr_en        = 1'b0;
    wr_idx       = '0;
    wr_data      = '0;
    wr2_en       = 1'b0;
    wr2_idx      = '0;
    wr2_data     = '0;
    mul_start    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          out_valid_nx = 1'b1;
          succ_nx      = 1'b1;
          ovf_nx       = 1'b0;
          case (opcode)
            OP_NOP: begin
            end
            OP_PUSH: begin
              if (full) begin
                succ_nx = 1'b0;
              end else begin
                wr_en    = 1'b1;
                wr_idx   = push_idx;
                wr_data  = input_data;
                depth_nx = depth + 1'b1;
                data_nx  = input_data;
              end
            end
            OP_POP: begin
              if (empty) begin
                succ_nx = 1'b0;
              end else begin
                depth_nx = depth - 1'b1;
                data_nx  = t_val;
              end
            end
            OP_DUP: begin
              if (full || empty) begin
                succ_nx = 1'b0;
              end else begin
                wr_en    = 1'b1;
                wr_idx   = push_idx;
                wr_data  = t_val;
                depth_nx = depth + 1'b1;
                data_nx  = t_val;
              end
            end
            OP_SWAP: begin
              if (!two_ok) begin
                succ_nx = 1'b0;
              end else begin
                wr_en    = 1'b1;
                wr_idx   = top_idx;
                wr_data  = s_val;
                wr2_en   = 1'b1;
                wr2_idx  = sec_idx;
                wr2_data = t_val;
                data_nx  = s_val;
              end
            end
            OP_ADD, OP_SUB: begin
              if (!two_ok) begin
                succ_nx = 1'b0;
              end else begin
                wr_en    = 1'b1;
                wr_idx   = sec_idx;
                wr_data  = ar_res;
                depth_nx = depth - 1'b1;
                data_nx  = ar_res;
                ovf_nx   = ar_ovf;
              end
            end
            OP_MUL: begin
              if (!two_ok) begin
                succ_nx = 1'b0;
              end else begin
                out_valid_nx = 1'b0;
                succ_nx      = success;
                ovf_nx       = overflow;
                mul_start    = 1'b1;
                state_nx     = MUL_BUSY;
              end
            end
            default: begin
            end
          endcase
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          state_nx     = IDLE;
          out_valid_nx = 1'b1;
          succ_nx      = 1'b1;
          ovf_nx       = mul_ovf;
          data_nx      = mul_res;
          wr_en        = 1'b1;
          wr_idx       = sec_idx;
          wr_data      = mul_res;
          depth_nx     = depth - 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      output_data <= '0;
      overflow    <= 1'b0;
      success     <= 1'b0;
      depth       <= '0;
    end else begin
      out_valid   <= out_valid_nx;
      output_data <= data_nx;
      overflow    <= ovf_nx;
      success     <= succ_nx;
      depth       <= depth_nx;
    end
  end

  // Stack storage carries no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (wr2_en) begin
      mem[wr2_idx] <= wr2_data;
    end
  end

endmodule

// File: tb/tb_stack_alu_hs.sv
// Directed self-checking bench for stack_alu_hs at N=4, DEPTH=4; honours
// STACK_ALU_SATURATE_EN for the expected overflow results.
module tb_stack_alu_hs;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  localparam logic [2:0] C_NOP  = 3'b000;
  localparam logic [2:0] C_SUB  = 3'b001;
  localparam logic [2:0] C_DUP  = 3'b010;
  localparam logic [2:0] C_SWAP = 3'b011;
  localparam logic [2:0] C_ADD  = 3'b100;
  localparam logic [2:0] C_MUL  = 3'b101;
  localparam logic [2:0] C_PUSH = 3'b110;
  localparam logic [2:0] C_POP  = 3'b111;

`ifdef STACK_ALU_SATURATE_EN
  localparam logic [N-1:0] EXP_ADD_OV = 4'h7;
  localparam logic [N-1:0] EXP_MUL_OV = 4'h8;
`else
  localparam logic [N-1:0] EXP_ADD_OV = 4'h8;
  localparam logic [N-1:0] EXP_MUL_OV = 4'h4;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   opcode = 3'b000;
  logic [N-1:0] input_data = '0;
  logic [N-1:0] output_data;
  logic         out_valid;
  logic         overflow;
  logic         success;
  logic [2:0]   depth;
  logic         full;
  logic         empty;

  int n_cmp = 0;
  int n_bad = 0;

  stack_alu_hs #(.N(N), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .input_data  (input_data),
    .output_data (output_data),
    .out_valid   (out_valid),
    .overflow    (overflow),
    .success     (success),
    .depth       (depth),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  // Present one command for a single accepting edge; returns 1 ns after it.
  task automatic send(input logic [2:0] op, input logic [N-1:0] d);
    @(negedge clk);
    in_valid   = 1'b1;
    opcode     = op;
    input_data = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (depth !== 3'd0) begin n_bad++; $display("[TB] FAIL rst_depth: got %0d want 0", depth); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_full: got %b want 0", full); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (output_data !== 4'h0) begin n_bad++; $display("[TB] FAIL rst_data: got %h want 0", output_data); end
    n_cmp++; if (overflow !== 1'b0 || success !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_flags: got ovf %b succ %b want 0 0", overflow, success); end
  endtask

  task automatic test_add_overflow();
    send(C_PUSH, 4'd3);
    n_cmp++; if (out_valid !== 1'b1 || output_data !== 4'd3 || success !== 1'b1 || depth !== 3'd1) begin
      n_bad++; $display("[TB] FAIL push3: got v%b d%h s%b dep%0d want v1 d3 s1 dep1", out_valid, output_data, success, depth); end
    send(C_PUSH, 4'd5);
    send(C_ADD, 4'd0);
    n_cmp++; if (output_data !== EXP_ADD_OV) begin n_bad++; $display("[TB] FAIL add_data: got %h want %h", output_data, EXP_ADD_OV); end
    n_cmp++; if (overflow !== 1'b1 || success !== 1'b1) begin n_bad++; $display("[TB] FAIL add_flags: got ovf %b succ %b want 1 1", overflow, success); end
    n_cmp++; if (depth !== 3'd1) begin n_bad++; $display("[TB] FAIL add_depth: got %0d want 1", depth); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin n_bad++; $display("[TB] FAIL add_pulse_hold: got v%b ovf%b want v0 ovf1", out_valid, overflow); end
    send(C_POP, 4'd0);
    n_cmp++; if (output_data !== EXP_ADD_OV || depth !== 3'd0 || overflow !== 1'b0) begin
      n_bad++; $display("[TB] FAIL add_pop: got d%h dep%0d ovf%b want d%h dep0 ovf0", output_data, depth, overflow, EXP_ADD_OV); end
  endtask

  task automatic test_mul();
    int lat;
    int busy;
    send(C_PUSH, 4'hE);
    send(C_PUSH, 4'd3);
    send(C_MUL, 4'd0);
    lat  = 1;
    busy = 0;
    while (!out_valid && lat < 20) begin
      if (!in_ready) busy++;
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL mul_timeout: got out_valid %b want 1", out_valid); end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("[TB] FAIL mul_latency: got %0d want 5", lat); end
    n_cmp++; if (busy !== 4) begin n_bad++; $display("[TB] FAIL mul_busy_cycles: got %0d want 4", busy); end
    n_cmp++; if (output_data !== 4'hA || overflow !== 1'b0 || success !== 1'b1) begin
      n_bad++; $display("[TB] FAIL mul_result: got d%h ovf%b s%b want dA ovf0 s1", output_data, overflow, success); end
    n_cmp++; if (depth !== 3'd1 || in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL mul_depth: got dep%0d rdy%b want 1 1", depth, in_ready); end
    send(C_POP, 4'd0);
    // 4 * -3 = -12 does not fit in 4 signed bits
    send(C_PUSH, 4'd4);
    send(C_PUSH, 4'hD);
    send(C_MUL, 4'd0);
    wait_done(lat);
    n_cmp++; if (output_data !== EXP_MUL_OV || overflow !== 1'b1 || lat !== 5) begin
      n_bad++; $display("[TB] FAIL mul_ovf: got d%h ovf%b lat%0d want d%h ovf1 lat5", output_data, overflow, lat, EXP_MUL_OV); end
    send(C_POP, 4'd0);
  endtask

  task automatic test_illegal();
    send(C_POP, 4'd0);
    n_cmp++; if (out_valid !== 1'b1 || success !== 1'b0 || overflow !== 1'b0) begin
      n_bad++; $display("[TB] FAIL pop_empty_flags: got v%b s%b ovf%b want v1 s0 ovf0", out_valid, success, overflow); end
    n_cmp++; if (output_data !== EXP_MUL_OV || depth !== 3'd0) begin
      n_bad++; $display("[TB] FAIL pop_empty_hold: got d%h dep%0d want d%h dep0", output_data, depth, EXP_MUL_OV); end
    for (int i = 1; i <= 4; i++) send(C_PUSH, 4'(i));
    n_cmp++; if (full !== 1'b1 || depth !== 3'd4) begin n_bad++; $display("[TB] FAIL fill: got full%b dep%0d want 1 4", full, depth); end
    send(C_PUSH, 4'd5);
    n_cmp++; if (success !== 1'b0 || full !== 1'b1 || depth !== 3'd4 || output_data !== 4'd4) begin
      n_bad++; $display("[TB] FAIL push_full: got s%b full%b dep%0d d%h want s0 1 4 d4", success, full, depth, output_data); end
    send(C_DUP, 4'd0);
    n_cmp++; if (success !== 1'b0 || depth !== 3'd4) begin n_bad++; $display("[TB] FAIL dup_full: got s%b dep%0d want s0 dep4", success, depth); end
    send(C_POP, 4'd0);
    n_cmp++; if (output_data !== 4'd4 || success !== 1'b1 || depth !== 3'd3) begin
      n_bad++; $display("[TB] FAIL pop_top: got d%h s%b dep%0d want d4 s1 dep3", output_data, success, depth); end
    for (int i = 0; i < 3; i++) send(C_POP, 4'd0);
    n_cmp++; if (output_data !== 4'd1 || empty !== 1'b1) begin n_bad++; $display("[TB] FAIL pop_order: got d%h empty%b want d1 1", output_data, empty); end
    send(C_PUSH, 4'd1);
    send(C_ADD, 4'd0);
    n_cmp++; if (success !== 1'b0 || depth !== 3'd1 || output_data !== 4'd1) begin
      n_bad++; $display("[TB] FAIL add_short: got s%b dep%0d d%h want s0 dep1 d1", success, depth, output_data); end
    send(C_NOP, 4'd0);
    n_cmp++; if (out_valid !== 1'b1 || success !== 1'b1 || depth !== 3'd1) begin
      n_bad++; $display("[TB] FAIL nop: got v%b s%b dep%0d want v1 s1 dep1", out_valid, success, depth); end
    send(C_POP, 4'd0);
  endtask

  task automatic test_swap_sub();
    send(C_PUSH, 4'd6);
    send(C_PUSH, 4'd2);
    send(C_SWAP, 4'd0);
    n_cmp++; if (output_data !== 4'd6 || depth !== 3'd2 || success !== 1'b1) begin
      n_bad++; $display("[TB] FAIL swap: got d%h dep%0d s%b want d6 dep2 s1", output_data, depth, success); end
    send(C_SUB, 4'd0);
    n_cmp++; if (output_data !== 4'hC || overflow !== 1'b0 || depth !== 3'd1) begin
      n_bad++; $display("[TB] FAIL sub: got d%h ovf%b dep%0d want dC ovf0 dep1", output_data, overflow, depth); end
    send(C_DUP, 4'd0);
    n_cmp++; if (depth !== 3'd2 || output_data !== 4'hC) begin n_bad++; $display("[TB] FAIL dup: got dep%0d d%h want dep2 dC", depth, output_data); end
    send(C_POP, 4'd0);
    n_cmp++; if (output_data !== 4'hC || depth !== 3'd1) begin n_bad++; $display("[TB] FAIL dup_pop: got d%h dep%0d want dC dep1", output_data, depth); end
    send(C_POP, 4'd0);
  endtask

  task automatic test_mul_reset();
    int seen;
    send(C_PUSH, 4'd2);
    send(C_PUSH, 4'd3);
    send(C_MUL, 4'd0);
    @(posedge clk); #1;
    rst  = 1'b1;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("[TB] FAIL mulrst_no_valid: got %0d pulses want 0", seen); end
    n_cmp++; if (in_ready !== 1'b1 || depth !== 3'd0 || empty !== 1'b1) begin
      n_bad++; $display("[TB] FAIL mulrst_state: got rdy%b dep%0d empty%b want 1 0 1", in_ready, depth, empty); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int depth_bad;
    send(C_PUSH, 4'd2);
    send(C_PUSH, 4'd3);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = C_MUL;
    @(posedge clk); #1;
    opcode     = C_PUSH;
    input_data = 4'd7;
    lat        = 1;
    depth_bad  = 0;
    while (!out_valid && lat < 20) begin
      if (depth !== 3'd2) depth_bad++;
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (depth_bad !== 0) begin n_bad++; $display("[TB] FAIL held_busy_depth: got %0d bad samples want 0", depth_bad); end
    n_cmp++; if (lat !== 5 || output_data !== 4'd6 || depth !== 3'd1 || in_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL held_mul: got lat%0d d%h dep%0d rdy%b want 5 d6 dep1 rdy1", lat, output_data, depth, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || output_data !== 4'd7 || depth !== 3'd2) begin
      n_bad++; $display("[TB] FAIL held_push: got v%b d%h dep%0d want v1 d7 dep2", out_valid, output_data, depth); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_mul();
    test_illegal();
    test_swap_sub();
    test_mul_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
